// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and default sizes for the writeback arbiter slice.
//   wb_entry_t : one pending register-file write {rd, data} at default widths
//   wb_src_e   : identifies which producer (ALU or load unit) was granted
// Optional feature macro used by this slice: WB_FIXED_PRIO_EN
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_WIDTH = 64;
    localparam int WB_NUM_REGS   = 32;
    localparam int WB_DEPTH      = 4;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [$clog2(WB_NUM_REGS)-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small in-order synchronous FIFO holding pending writeback entries.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_entry  : enqueue request and the entry to store
//   pop               : dequeue the current head
//   head              : entry at the front of the queue
//   count             : number of stored entries (0..DEPTH)
//   full, empty       : occupancy flags derived from count
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // The storage array carries no reset: an entry is only ever read after
    // it has been written, and the count/pointers below decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy. A simultaneous push and pop leaves the count
    // unchanged; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = storage[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Collects results from the ALU and the load unit, keeps them in program
// (acceptance) order, and issues at most one register-file write per cycle.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   alu_valid/alu_ready, alu_rd/alu_data: ALU result handshake
//   mem_valid/mem_ready, mem_rd/mem_data: load-unit result handshake
//   wb_stall                            : hold writeback this cycle
//   write_reg/write_data                : registered write port (0/0 = idle)
//   wb_empty                            : nothing buffered and output idle
// Configuration macro: WB_FIXED_PRIO_EN
//   defined   : the load unit always wins a tie, no round-robin state
//   undefined : round-robin between the two sources on ties
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int NUM_REGS     = WB_NUM_REGS,
    parameter int NUM_REGS_LOG = $clog2(NUM_REGS),
    parameter int DEPTH        = WB_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [NUM_REGS_LOG-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [NUM_REGS_LOG-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    wb_stall,
    output logic [NUM_REGS_LOG-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    wb_empty
);

    typedef struct packed {
        logic [NUM_REGS_LOG-1:0] rd;
        logic [DATA_WIDTH-1:0]   data;
    } entry_t;

    logic                       grant_alu;
    logic                       grant_mem;
    logic                       accept;
    logic                       keep;
    logic                       push;
    logic                       pop;
    entry_t                     acc_entry;
    entry_t                     fifo_head;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;

`ifndef WB_FIXED_PRIO_EN
    wb_src_e                    rr_last;
`endif

    // Grant selection. A lone valid source always wins; a tie goes either to
    // the load unit (fixed priority) or to whichever source did not win the
    // last completed transfer.
    always_comb begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
        if (alu_valid && mem_valid) begin
`ifdef WB_FIXED_PRIO_EN
            grant_alu = 1'b0;
            grant_mem = 1'b1;
`else
            grant_alu = (rr_last == WB_SRC_MEM);
            grant_mem = (rr_last == WB_SRC_ALU);
`endif
        end
    end

    // Ready looks only at the current occupancy, so a pop happening in the
    // same cycle does not open a slot until the next cycle.
    assign alu_ready = grant_alu && !fifo_full;
    assign mem_ready = grant_mem && !fifo_full;
    assign accept    = alu_ready || mem_ready;

    // Entry from the granted source. Writes to register 0 still complete the
    // handshake but are dropped here so they never reach the queue or port.
    always_comb begin
        acc_entry.rd   = mem_rd;
        acc_entry.data = mem_data;
        if (grant_alu) begin
            acc_entry.rd   = alu_rd;
            acc_entry.data = alu_data;
        end
    end

    assign keep = accept && (acc_entry.rd != '0);

    // The head leaves whenever writeback is not stalled. A kept entry goes
    // into the queue unless it can bypass straight to the output, which is
    // only legal when nothing older is waiting and writeback is free.
    assign pop  = !wb_stall && !fifo_empty;
    assign push = keep && (wb_stall || !fifo_empty);

    wb_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (acc_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

`ifndef WB_FIXED_PRIO_EN
    // Remember the winner of the last completed transfer (discarded rd==0
    // transfers count too). Starting at MEM lets the ALU win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= WB_SRC_MEM;
        end else if (accept) begin
            rr_last <= grant_alu ? WB_SRC_ALU : WB_SRC_MEM;
        end
    end
`endif

    // Output register. Stall forces an idle write; otherwise the oldest
    // buffered entry goes first, then a bypassing fresh entry, else idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg  <= '0;
            write_data <= '0;
        end else if (wb_stall) begin
            write_reg  <= '0;
            write_data <= '0;
        end else if (!fifo_empty) begin
            write_reg  <= fifo_head.rd;
            write_data <= fifo_head.data;
        end else if (keep) begin
            write_reg  <= acc_entry.rd;
            write_data <= acc_entry.data;
        end else begin
            write_reg  <= '0;
            write_data <= '0;
        end
    end

    assign wb_empty = (fifo_count == '0) && (write_reg == '0);

endmodule
